// File: rtl/asi_r.sv
// AXI slave read interface: queues AR requests, walks each burst against a
// fixed-latency local RAM and returns R beats in request order.
module asi_r #(
   parameter int AXI_DW = 128,
   parameter int AXI_AW = 32,
   parameter int AXI_IW = 8,
   parameter int AXI_LW = 8,
   parameter int AXI_SW = 3,
   parameter int ASI_AD = 4,
   parameter int ASI_RD = 16,
   parameter int RAM_WS = 2
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [AXI_IW-1:0] ARID,
   input  logic [AXI_AW-1:0] ARADDR,
   input  logic [AXI_LW-1:0] ARLEN,
   input  logic [AXI_SW-1:0] ARSIZE,
   input  logic [1:0]        ARBURST,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [AXI_IW-1:0] RID,
   output logic [AXI_DW-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              RLAST,
   output logic              RVALID,
   input  logic              RREADY,
   output logic              mem_re,
   output logic [AXI_AW-1:0] mem_raddr,
   input  logic [AXI_DW-1:0] mem_rdata
);

   localparam int BPB_LG = $clog2(AXI_DW / 8);
   localparam int AF_AW  = $clog2(ASI_AD);
   localparam int RF_AW  = $clog2(ASI_RD);
   localparam int AF_W   = AXI_IW + AXI_AW + AXI_LW + AXI_SW + 2;
   localparam int RF_W   = AXI_IW + AXI_DW + 3;
   localparam int INF_W  = AXI_IW + 3;
   localparam logic [AF_AW:0]    AF_FULL  = (AF_AW + 1)'(ASI_AD);
   localparam logic [RF_AW+1:0]  RF_LIM   = (RF_AW + 2)'(ASI_RD);
   localparam logic [AXI_SW-1:0] SIZE_MAX = AXI_SW'(BPB_LG);

   typedef enum logic [0:0] {IDLE, BURST} state_t;

   // Next beat address for FIXED / INCR / WRAP; reserved burst walks as INCR.
   function automatic logic [AXI_AW-1:0] next_addr(
      input logic [AXI_AW-1:0] addr,
      input logic [AXI_LW-1:0] len,
      input logic [AXI_SW-1:0] size,
      input logic [1:0]        burst
   );
      logic [AXI_AW-1:0] bytes;
      logic [AXI_AW-1:0] mask;
      bytes = {{(AXI_AW - 1){1'b0}}, 1'b1} << size;
      mask  = (({{(AXI_AW - AXI_LW){1'b0}}, len} + 1'b1) << size) - 1'b1;
      case (burst)
         2'b00:   next_addr = addr;
         2'b10:   next_addr = (addr & ~mask) | ((addr + bytes) & mask);
         default: next_addr = (addr & ~(bytes - 1'b1)) + bytes;
      endcase
   endfunction

   // A burst is answered with SLVERR on every beat when it cannot be honoured.
   function automatic logic burst_err(
      input logic [AXI_LW-1:0] len,
      input logic [AXI_SW-1:0] size,
      input logic [1:0]        burst
   );
      logic wrap_ok;
      wrap_ok = (len == AXI_LW'(1)) || (len == AXI_LW'(3)) ||
                (len == AXI_LW'(7)) || (len == AXI_LW'(15));
      burst_err = (burst == 2'b11) || (size > SIZE_MAX) ||
                  ((burst == 2'b10) && !wrap_ok);
   endfunction

   // AR FIFO
   logic [AF_W-1:0]   af_mem [ASI_AD];
   logic [AF_AW-1:0]  af_wp, af_rp;
   logic [AF_AW:0]    af_cnt;
   logic              af_push, af_pop, af_empty;
   logic [AXI_IW-1:0] h_id;
   logic [AXI_AW-1:0] h_addr;
   logic [AXI_LW-1:0] h_len;
   logic [AXI_SW-1:0] h_size;
   logic [1:0]        h_burst;

   assign af_empty = (af_cnt == '0);
   assign ARREADY  = !ARESET && (af_cnt != AF_FULL);
   assign af_push  = ARVALID && ARREADY;
   assign {h_id, h_addr, h_len, h_size, h_burst} = af_mem[af_rp];

   // AR FIFO storage write
   always_ff @(posedge ACLK) begin
      if (af_push) af_mem[af_wp] <= {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
   end

   // AR FIFO pointers and occupancy
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         af_wp  <= '0;
         af_rp  <= '0;
         af_cnt <= '0;
      end else begin
         if (af_push) af_wp <= af_wp + 1'b1;
         if (af_pop)  af_rp <= af_rp + 1'b1;
         case ({af_push, af_pop})
            2'b10:   af_cnt <= af_cnt + 1'b1;
            2'b01:   af_cnt <= af_cnt - 1'b1;
            default: af_cnt <= af_cnt;
         endcase
      end
   end

   // Burst walker
   state_t            state, state_nxt;
   logic [AXI_IW-1:0] b_id;
   logic [AXI_AW-1:0] b_addr;
   logic [AXI_LW-1:0] b_len, b_cnt;
   logic [AXI_SW-1:0] b_size;
   logic [1:0]        b_burst;
   logic              b_err;
   logic              load, issue, credit, b_last;
   logic [RF_AW:0]    rff_cnt;
   logic [RF_AW:0]    inflight;
   logic [RAM_WS-1:0] vld_p;

   assign inflight = (RF_AW + 1)'($countones(vld_p));
   assign credit   = ({1'b0, rff_cnt} + {1'b0, inflight}) < RF_LIM;
   assign b_last   = (b_cnt == b_len);

   // FSM state register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state: load a burst when idle, issue one RAM read per credited cycle,
   // and chain straight into the next queued burst on the last beat
   always_comb begin
      state_nxt = state;
      af_pop    = 1'b0;
      load      = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (!af_empty) begin
               af_pop    = 1'b1;
               load      = 1'b1;
               state_nxt = BURST;
            end
         end
         BURST: begin
            if (credit) begin
               issue = 1'b1;
               if (b_last) begin
                  if (!af_empty) begin
                     af_pop = 1'b1;
                     load   = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Burst registers: load from the AR FIFO head, advance on every issued beat
   always_ff @(posedge ACLK) begin
      if (load) begin
         b_id    <= h_id;
         b_addr  <= h_addr;
         b_len   <= h_len;
         b_size  <= h_size;
         b_burst <= h_burst;
         b_err   <= burst_err(h_len, h_size, h_burst);
         b_cnt   <= '0;
      end else if (issue) begin
         b_addr  <= next_addr(b_addr, b_len, b_size, b_burst);
         b_cnt   <= b_cnt + 1'b1;
      end
   end

   assign mem_re    = issue;
   assign mem_raddr = b_addr >> BPB_LG;

   // ---- stage p0..p(RAM_WS-1): beat attributes travel alongside the RAM read ----
   logic [INF_W-1:0] inf_p [RAM_WS];
   logic [INF_W-1:0] inf_out;

   assign inf_out = inf_p[RAM_WS-1];

   // Return pipeline valid bits
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) vld_p <= '0;
      else        vld_p <= (vld_p << 1) | RAM_WS'(issue);
   end

   // Return pipeline beat attributes {id, resp, last}
   always_ff @(posedge ACLK) begin
      inf_p[0] <= {b_id, (b_err ? 2'b10 : 2'b00), b_last};
      for (int i = 1; i < RAM_WS; i++) inf_p[i] <= inf_p[i-1];
   end

   // ---- R FIFO: written when the RAM data and its attributes line up ----
   logic [RF_W-1:0]  rf_mem [ASI_RD];
   logic [RF_AW-1:0] rf_wp, rf_rp;
   logic             rf_push, rf_pop, rf_hlast;

   assign rf_push = vld_p[RAM_WS-1];
   assign RVALID  = (rff_cnt != '0);
   assign rf_pop  = RVALID && RREADY;
   assign {RID, RDATA, RRESP, rf_hlast} = rf_mem[rf_rp];
   assign RLAST   = RVALID && rf_hlast;

   // R FIFO storage write
   always_ff @(posedge ACLK) begin
      if (rf_push) rf_mem[rf_wp] <= {inf_out[INF_W-1:3], mem_rdata, inf_out[2:0]};
   end

   // R FIFO pointers and occupancy
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rf_wp   <= '0;
         rf_rp   <= '0;
         rff_cnt <= '0;
      end else begin
         if (rf_push) rf_wp <= rf_wp + 1'b1;
         if (rf_pop)  rf_rp <= rf_rp + 1'b1;
         case ({rf_push, rf_pop})
            2'b10:   rff_cnt <= rff_cnt + 1'b1;
            2'b01:   rff_cnt <= rff_cnt - 1'b1;
            default: rff_cnt <= rff_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_asi_r.sv
// Directed bench for asi_r: a RAM model with fixed read latency feeds the DUT,
// R beats and RAM reads are logged on the falling edge and compared with
// hand-derived expectations.
module tb_asi_r;

   localparam int DW = 128;
   localparam int AW = 32;
   localparam int IW = 8;
   localparam int LW = 8;
   localparam int SW = 3;
   localparam int AD = 4;
   localparam int RD = 16;
   localparam int WS = 2;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [IW-1:0] ARID;
   logic [AW-1:0] ARADDR;
   logic [LW-1:0] ARLEN;
   logic [SW-1:0] ARSIZE;
   logic [1:0]    ARBURST;
   logic          ARVALID;
   logic          ARREADY;
   logic [IW-1:0] RID;
   logic [DW-1:0] RDATA;
   logic [1:0]    RRESP;
   logic          RLAST;
   logic          RVALID;
   logic          RREADY;
   logic          mem_re;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;

   asi_r #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW),
           .ASI_AD(AD), .ASI_RD(RD), .RAM_WS(WS)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
   );

   always #5 ACLK = ~ACLK;

   // Word content of the RAM model, a function of the word address
   function automatic logic [127:0] ram_word(input logic [31:0] a);
      return {a, ~a, a ^ 32'h5A5A_A5A5, a + 32'h1234_5678};
   endfunction

   logic [AW-1:0] rd_dly [WS];
   always @(posedge ACLK) begin
      rd_dly[0] <= mem_raddr;
      for (int i = 1; i < WS; i++) rd_dly[i] <= rd_dly[i-1];
   end
   assign mem_rdata = ram_word(rd_dly[WS-1]);

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   logic [7:0]   qid[$];
   logic [127:0] qdat[$];
   logic [1:0]   qresp[$];
   logic         qlast[$];
   int           qcyc[$];
   logic [31:0]  qaddr[$];
   int           qacyc[$];
   int           ar_cyc = 0;
   int           rv_first = -1;

   always @(negedge ACLK) begin
      if (RVALID && RREADY) begin
         qid.push_back(RID);
         qdat.push_back(RDATA);
         qresp.push_back(RRESP);
         qlast.push_back(RLAST);
         qcyc.push_back(cyc);
      end
      if (mem_re) begin
         qaddr.push_back(mem_raddr);
         qacyc.push_back(cyc);
      end
      if (ARVALID && ARREADY) ar_cyc = cyc;
      if (RVALID && rv_first < 0) rv_first = cyc;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   task automatic clear_q();
      qid.delete(); qdat.delete(); qresp.delete(); qlast.delete(); qcyc.delete();
      qaddr.delete(); qacyc.delete();
      rv_first = -1;
   endtask

   // Presents one AR; leaves ARVALID high so calls can run back to back
   task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int maxw, output bit ok);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < maxw && !ok; i++) begin
         @(negedge ACLK);
         if (ARREADY) ok = 1'b1;
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic wait_beats(input int n, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (qid.size() >= n) break;
         tick(1);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int nacc;
      logic [31:0] e2 [4];
      logic [7:0]  e5id [7];
      e2   = '{32'h13, 32'h10, 32'h11, 32'h12};
      e5id = '{8'h55, 8'h55, 8'h55, 8'h56, 8'h57, 8'h57, 8'h57};

      ARESET = 1'b1; ARVALID = 1'b0; RREADY = 1'b0;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;

      // Reset state
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_arready", 128'(ARREADY), 128'(0));
      chk("rst_rvalid",  128'(RVALID),  128'(0));
      chk("rst_mem_re",  128'(mem_re),  128'(0));
      chk("rst_rlast",   128'(RLAST),   128'(0));
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      tick(1);
      chk("rst_arready_rel", 128'(ARREADY), 128'(1));

      // 1: INCR burst, latency and beat contents
      clear_q();
      RREADY = 1'b1;
      send_ar(8'h11, 32'h100, 8'd3, 3'd4, 2'b01, 4, ok);
      ARVALID = 1'b0;
      chk("t1_accept", 128'(ok), 128'(1));
      wait_beats(4, 30);
      tick(5);
      chk("t1_nbeats", 128'(qid.size()), 128'(4));
      chk("t1_nreads", 128'(qaddr.size()), 128'(4));
      for (int i = 0; i < 4 && i < qaddr.size(); i++)
         chk($sformatf("t1_addr%0d", i), 128'(qaddr[i]), 128'(32'h10 + i));
      for (int i = 0; i < 4 && i < qid.size(); i++) begin
         chk($sformatf("t1_id%0d", i),   128'(qid[i]),   128'(8'h11));
         chk($sformatf("t1_last%0d", i), 128'(qlast[i]), 128'(i == 3));
         chk($sformatf("t1_resp%0d", i), 128'(qresp[i]), 128'(0));
         chk($sformatf("t1_data%0d", i), qdat[i], ram_word(32'h10 + i));
      end
      if (qacyc.size() > 0) chk("t1_lat_re", 128'(qacyc[0] - ar_cyc), 128'(2));
      chk("t1_lat_rv", 128'(rv_first - ar_cyc), 128'(WS + 3));

      // 2: WRAP burst
      clear_q();
      send_ar(8'h22, 32'h130, 8'd3, 3'd4, 2'b10, 4, ok);
      ARVALID = 1'b0;
      wait_beats(4, 30);
      tick(5);
      chk("t2_nbeats", 128'(qid.size()), 128'(4));
      for (int i = 0; i < 4 && i < qaddr.size(); i++)
         chk($sformatf("t2_addr%0d", i), 128'(qaddr[i]), 128'(e2[i]));
      for (int i = 0; i < 4 && i < qid.size(); i++) begin
         chk($sformatf("t2_last%0d", i), 128'(qlast[i]), 128'(i == 3));
         chk($sformatf("t2_data%0d", i), qdat[i], ram_word(e2[i]));
      end

      // 3: back-pressure, credit stop, AR FIFO fill, then drain
      clear_q();
      RREADY = 1'b0;
      send_ar(8'h33, 32'h0, 8'd15, 3'd4, 2'b01, 4, ok);
      ARVALID = 1'b0;
      tick(40);
      chk("t3_reads_stalled", 128'(qaddr.size()), 128'(16));
      chk("t3_rvalid", 128'(RVALID), 128'(1));
      chk("t3_rid",    128'(RID),    128'(8'h33));
      chk("t3_rlast",  128'(RLAST),  128'(0));
      chk("t3_rdata",  RDATA, ram_word(32'h0));
      nacc = 0;
      for (int k = 0; k < 8; k++) begin
         send_ar(8'(8'h41 + k), 32'(32'h200 + k * 16), 8'd0, 3'd4, 2'b01, 3, ok);
         if (!ok) break;
         nacc++;
      end
      ARVALID = 1'b0;
      chk("t3_ar_accepted", 128'(nacc), 128'(AD + 1));
      chk("t3_arready_full", 128'(ARREADY), 128'(0));
      tick(3);
      chk("t3_no_new_read", 128'(qaddr.size()), 128'(16));
      chk("t3_rid_held",   128'(RID), 128'(8'h33));
      chk("t3_rdata_held", RDATA, ram_word(32'h0));
      chk("t3_no_beats",   128'(qid.size()), 128'(0));
      RREADY = 1'b1;
      wait_beats(21, 80);
      tick(10);
      chk("t3_nbeats", 128'(qid.size()), 128'(21));
      chk("t3_nreads", 128'(qaddr.size()), 128'(21));
      for (int i = 0; i < 16 && i < qid.size(); i++) begin
         chk($sformatf("t3_id%0d", i),   128'(qid[i]),   128'(8'h33));
         chk($sformatf("t3_data%0d", i), qdat[i], ram_word(32'(i)));
         chk($sformatf("t3_last%0d", i), 128'(qlast[i]), 128'(i == 15));
      end
      for (int k = 0; k < 5 && 16 + k < qid.size(); k++) begin
         chk($sformatf("t3_sid%0d", k),   128'(qid[16+k]),   128'(8'(8'h41 + k)));
         chk($sformatf("t3_sdata%0d", k), qdat[16+k], ram_word(32'(32'h20 + k)));
         chk($sformatf("t3_slast%0d", k), 128'(qlast[16+k]), 128'(1));
      end

      // 4: five back-to-back bursts, no gap between them
      clear_q();
      nacc = 0;
      for (int k = 1; k <= 5; k++) begin
         send_ar(8'(k), 32'(32'h400 + 32'h20 * (k - 1)), 8'd1, 3'd4, 2'b01, 4, ok);
         if (ok) nacc++;
      end
      ARVALID = 1'b0;
      chk("t4_accepted", 128'(nacc), 128'(5));
      wait_beats(10, 40);
      tick(10);
      chk("t4_nbeats", 128'(qid.size()), 128'(10));
      for (int i = 0; i < 10 && i < qid.size(); i++) begin
         chk($sformatf("t4_id%0d", i),   128'(qid[i]),   128'(8'(i / 2 + 1)));
         chk($sformatf("t4_last%0d", i), 128'(qlast[i]), 128'(i % 2));
         chk($sformatf("t4_data%0d", i), qdat[i], ram_word(32'(32'h40 + i)));
         if (i > 0) chk($sformatf("t4_gap%0d", i), 128'(qcyc[i] - qcyc[i-1]), 128'(1));
      end

      // 5: error bursts: reserved type, oversize beat, illegal wrap length
      clear_q();
      send_ar(8'h55, 32'h500, 8'd2, 3'd4, 2'b11, 4, ok);
      send_ar(8'h56, 32'h560, 8'd0, 3'd5, 2'b01, 4, ok);
      send_ar(8'h57, 32'h580, 8'd2, 3'd4, 2'b10, 4, ok);
      ARVALID = 1'b0;
      wait_beats(7, 40);
      tick(10);
      chk("t5_nbeats", 128'(qid.size()), 128'(7));
      for (int i = 0; i < 7 && i < qid.size(); i++) begin
         chk($sformatf("t5_id%0d", i),   128'(qid[i]),   128'(e5id[i]));
         chk($sformatf("t5_resp%0d", i), 128'(qresp[i]), 128'(2'b10));
         chk($sformatf("t5_last%0d", i), 128'(qlast[i]), 128'(i == 2 || i == 3 || i == 6));
      end

      // 6: reset mid-burst
      clear_q();
      send_ar(8'h66, 32'h600, 8'd7, 3'd4, 2'b01, 4, ok);
      ARVALID = 1'b0;
      wait_beats(2, 30);
      chk("t6_pre_beats", 128'(qid.size() >= 2), 128'(1));
      ARESET = 1'b1;
      @(negedge ACLK);
      chk("t6_rst_rvalid",  128'(RVALID),  128'(0));
      chk("t6_rst_mem_re",  128'(mem_re),  128'(0));
      chk("t6_rst_arready", 128'(ARREADY), 128'(0));
      tick(2);
      ARESET = 1'b0;
      clear_q();
      tick(12);
      chk("t6_no_stale",  128'(qid.size()),   128'(0));
      chk("t6_no_reads",  128'(qaddr.size()), 128'(0));
      chk("t6_rvalid_lo", 128'(RVALID),       128'(0));
      send_ar(8'h67, 32'h700, 8'd0, 3'd4, 2'b01, 4, ok);
      ARVALID = 1'b0;
      chk("t6_accept", 128'(ok), 128'(1));
      wait_beats(1, 30);
      tick(12);
      chk("t6_nbeats", 128'(qid.size()), 128'(1));
      if (qid.size() > 0) begin
         chk("t6_id",   128'(qid[0]),   128'(8'h67));
         chk("t6_last", 128'(qlast[0]), 128'(1));
         chk("t6_resp", 128'(qresp[0]), 128'(0));
         chk("t6_data", qdat[0], ram_word(32'h70));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
